// File: rtl/memaccess_pkg.sv
// Shared encodings for the memaccess bus initiator: access sizes, FSM states
// and big-endian lane offsets.
package memaccess_pkg;

    localparam int WORD_W = 32;

    // Request size encodings
    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;
    localparam logic [1:0] SZ_ILL  = 2'b11;

    // Big-endian halfword offsets: offset 0 is [31:16], offset 2 is [15:0]
    localparam logic [1:0] OFF_HALF_HI = 2'd0;
    localparam logic [1:0] OFF_HALF_LO = 2'd2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2,
        RESP  = 2'd3
    } state_e;

    // Byte offset addressing the byte lane [8*lane+7 : 8*lane] (big-endian)
    function automatic logic [1:0] lane_off(input int lane);
        return 2'(3 - lane);
    endfunction

    // Misaligned or illegal request detection
    function automatic logic is_bad(input logic [1:0] size, input logic [1:0] off);
        return (size == SZ_ILL) ||
               ((size == SZ_HALF) && off[0]) ||
               ((size == SZ_WORD) && (off != 2'b00));
    endfunction

endpackage

// File: rtl/memaccess_lane.sv
// Combinational lane logic: extracts and extends the addressed lane for loads
// and merges right-justified store data into a word for sub-word stores.
module memlane
    import memaccess_pkg::*;
(
    input  logic [WORD_W-1:0] word,
    input  logic [1:0]        off,
    input  logic [1:0]        size,
    input  logic              sgn,
    input  logic [WORD_W-1:0] sdata,
    output logic [WORD_W-1:0] ldata,
    output logic [WORD_W-1:0] merged
);

    logic [4:0]  byte_shift;
    logic [7:0]  byte_v;
    logic [15:0] half_v;

    // Offset 0 is the most significant byte, so the shift is (3-off)*8
    assign byte_shift = {~off, 3'b000};
    assign byte_v     = word[byte_shift +: 8];
    assign half_v     = (off == OFF_HALF_LO) ? word[15:0] : word[31:16];

    // Load path: pick the lane and sign- or zero-extend it
    always_comb begin
        ldata = word;
        case (size)
            SZ_BYTE: ldata = {{24{sgn & byte_v[7]}}, byte_v};
            SZ_HALF: ldata = {{16{sgn & half_v[15]}}, half_v};
            default: ldata = word;
        endcase
    end

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            localparam logic [1:0] LANE_OFF = lane_off(gi);
            logic       lane_hit;
            logic [7:0] lane_byte;

            // Store path: decide whether this lane is overwritten and with which data byte
            always_comb begin
                lane_hit  = 1'b0;
                lane_byte = sdata[gi*8 +: 8];
                case (size)
                    SZ_BYTE: begin
                        lane_hit  = (off == LANE_OFF);
                        lane_byte = sdata[7:0];
                    end
                    SZ_HALF: begin
                        // Lower-offset byte of the halfword carries the high data byte
                        lane_hit  = (off[1] == LANE_OFF[1]);
                        lane_byte = LANE_OFF[0] ? sdata[7:0] : sdata[15:8];
                    end
                    SZ_WORD: lane_hit = 1'b1;
                    default: lane_hit = 1'b0;
                endcase
            end

            assign merged[gi*8 +: 8] = lane_hit ? lane_byte : word[gi*8 +: 8];
        end
    endgenerate

endmodule

// File: rtl/memaccess.sv
// Bus initiator between the multicycle MIPS datapath and word-wide data memory.
// Handles byte/halfword/word loads and stores with read-modify-write for
// sub-word stores; one response per request with an error flag.
module memaccess
    import memaccess_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic             req_write,
    input  logic [1:0]       req_size,
    input  logic             req_signed,
    input  logic [WIDTH-1:0] req_adr,
    input  logic [WIDTH-1:0] req_wdata,
    output logic             resp_valid,
    input  logic             resp_ready,
    output logic [WIDTH-1:0] resp_rdata,
    output logic             resp_err,
    output logic             memwrite,
    output logic [WIDTH-1:0] adr,
    output logic [WIDTH-1:0] writedata,
    input  logic [WIDTH-1:0] memdata
);

    generate
        if (WIDTH != WORD_W) begin : g_bad_width
            $error("memaccess: only WIDTH=32 is supported");
        end
    endgenerate

    state_e           state_reg;
    logic             write_reg;
    logic [1:0]       size_reg;
    logic             signed_reg;
    logic [WIDTH-1:0] adr_reg;
    logic [WIDTH-1:0] wdata_reg;   // store data, replaced by the merged word after READ
    logic [WIDTH-1:0] rdata_reg;
    logic             err_reg;

    logic [WIDTH-1:0] lane_ldata;
    logic [WIDTH-1:0] lane_merged;

    memlane u_lane (
        .word   (memdata),
        .off    (adr_reg[1:0]),
        .size   (size_reg),
        .sgn    (signed_reg),
        .sdata  (wdata_reg),
        .ldata  (lane_ldata),
        .merged (lane_merged)
    );

    // Request FSM: accept, read/merge, write, then hold the response until taken
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg  <= IDLE;
            write_reg  <= 1'b0;
            size_reg   <= SZ_BYTE;
            signed_reg <= 1'b0;
            adr_reg    <= '0;
            wdata_reg  <= '0;
            rdata_reg  <= '0;
            err_reg    <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (req_valid) begin
                        write_reg  <= req_write;
                        size_reg   <= req_size;
                        signed_reg <= req_signed;
                        adr_reg    <= req_adr;
                        wdata_reg  <= req_wdata;
                        rdata_reg  <= '0;
                        if (is_bad(req_size, req_adr[1:0])) begin
                            err_reg   <= 1'b1;
                            state_reg <= RESP;
                        end else begin
                            err_reg   <= 1'b0;
                            state_reg <= (req_write && (req_size == SZ_WORD)) ? WRITE : READ;
                        end
                    end
                end
                READ: begin
                    if (write_reg) begin
                        wdata_reg <= lane_merged;
                        state_reg <= WRITE;
                    end else begin
                        rdata_reg <= lane_ldata;
                        state_reg <= RESP;
                    end
                end
                WRITE: state_reg <= RESP;
                RESP: begin
                    if (resp_ready) begin
                        state_reg <= IDLE;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    // Outputs decoded from state so reset clears the memory strobes without a clock edge
    assign req_ready  = (state_reg == IDLE);
    assign resp_valid = (state_reg == RESP);
    assign resp_rdata = rdata_reg;
    assign resp_err   = err_reg;
    assign memwrite   = (state_reg == WRITE);
    assign adr        = ((state_reg == READ) || (state_reg == WRITE)) ?
                        {adr_reg[WIDTH-1:2], 2'b00} : '0;
    assign writedata  = (state_reg == WRITE) ? wdata_reg : '0;

endmodule

// File: doc/memaccess.md
Name: memaccess

Overview:
- Bus initiator that sits between the multicycle MIPS datapath and the word-wide data memory.
- Accepts byte, halfword and word load/store requests over a valid/ready handshake.
- Drives the memory's memwrite/adr/writedata/memdata interface.
- Performs read-modify-write for sub-word stores, and alignment plus sign/zero extension for loads.
- Returns one response per request, with an error flag for misaligned or illegal accesses.

Parameters:
- WIDTH, 32, data/address width. Only 32 is supported; any other value is a configuration error.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- req_valid  input  1  request present.
- req_ready  output  1  request can be accepted this cycle.
- req_write  input  1  1 = store, 0 = load.
- req_size  input  2  00 byte, 01 halfword, 10 word, 11 illegal.
- req_signed  input  1  loads only: 1 = sign-extend, 0 = zero-extend.
- req_adr  input  WIDTH  byte address.
- req_wdata  input  WIDTH  store data, right-justified (byte in [7:0], halfword in [15:0]).
- resp_valid  output  1  response present.
- resp_ready  input  1  response consumed.
- resp_rdata  output  WIDTH  extended load data; 0 for stores and errors.
- resp_err  output  1  misaligned or illegal request.
- memwrite  output  1  memory write enable.
- adr  output  WIDTH  memory byte address, low two bits always 0.
- writedata  output  WIDTH  memory write word.
- memdata  input  WIDTH  memory read word, combinational from adr.

Behaviour:
- Byte order is big-endian: adr[1:0]=0 selects bits [31:24]; halfword at offset 0 is [31:16], at offset 2 is [15:0].
- States: IDLE, READ, WRITE, RESP.
- IDLE
  - req_ready=1. On req_valid, latch write/size/signed/adr/wdata.
  - Error check: halfword with adr[0]=1, word with adr[1:0]!=0, or size 11. On error go to RESP with err=1, rdata=0, and no memory access.
  - Otherwise: load or sub-word store -> READ; word store -> WRITE.
- READ
  - adr = {latched_adr[31:2],2'b00}; memwrite=0; memdata captured at the clock edge.
  - Load: extract and extend the lane into the rdata register, then go to RESP.
  - Sub-word store: merge wdata into the captured word (other lanes preserved), then go to WRITE.
- WRITE
  - adr as in READ; writedata = merged word, or latched wdata for a word store.
  - memwrite=1 for exactly this one cycle; then go to RESP.
- RESP
  - resp_valid=1, req_ready=0. resp_rdata and resp_err hold stable until resp_ready.
  - On resp_valid && resp_ready go to IDLE. The next request may only be accepted in the following cycle; there is no same-cycle turnaround.
- Latency (acceptance edge = cycle N, resp_valid first high in the cycle shown):
  - Load: N+2.
  - Word store: N+2.
  - Sub-word store: N+3.
  - Error: N+1.
- Outside READ/WRITE: adr=0, writedata=0, memwrite=0. All outputs are registered or decoded from state only, never from req_*.
- Reset (reset_n=0, any time):
  - State goes to IDLE; resp_valid=0, resp_rdata=0, resp_err=0.
  - memwrite, adr and writedata drop to 0 immediately (asynchronously).
  - Any in-flight request is discarded with no response. A READ-phase RMW interrupted by reset leaves memory unmodified.
- req_valid while not in IDLE is ignored; the requester must hold it until req_ready.

Decomposition:
- Shared package memaccess_pkg:
  - size encodings SZ_BYTE/SZ_HALF/SZ_WORD;
  - state enum IDLE/READ/WRITE/RESP;
  - lane offset constants.
- Sub-module memlane (combinational), given the word, offset, size, signed flag and store data:
  - extract + extend for loads;
  - merge for stores.
- The FSM/registers stay in memaccess.

Test Plan:
- Load extension: memory word at 0x200 = 0x80F01234.
  - lb signed 0x201 -> rdata 0xFFFFFFF0.
  - lbu 0x201 -> 0x000000F0.
  - lh signed 0x200 -> 0xFFFF80F0.
  - lhu 0x202 -> 0x00001234.
  - lw 0x200 -> 0x80F01234; resp_valid at N+2.
- Sub-word store: word at 0x100 = 0x11223344.
  - sb 0xAB @0x102 -> memwrite high only in cycle N+2, writedata 0x1122AB44.
  - sh 0xBEEF @0x100 -> 0xBEEF3344.
  - resp at N+3, err=0.
- Misaligned: sw @0x102, lh @0x101, size 11 -> resp_err=1 at N+1, rdata 0, memwrite never asserted, memory unchanged.
- Backpressure: hold resp_ready=0 for 3 cycles after a lw -> resp_valid/rdata/err stable and req_ready=0 throughout. A queued request is accepted in the cycle after the response handshake.
- Reset mid-operation: reset_n=0 during WRITE of sb @0x102 -> memwrite falls with no clock edge, no response issued, req_ready=1 after release.
- Back-to-back: sw 0xCAFEF00D @0x300 then lw @0x300 -> reads 0xCAFEF00D.
